// File: rtl/mstream_transposer.sv
// 3x3 matrix stream transposer with ping-pong banks (column beats in/out).
// Optional stats counters enabled by MSTREAM_TRANSPOSER_STATS_EN.
module mstream_transposer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  ig_vld,
    output logic                  ig_rdy,
    input  logic [DATA_WIDTH-1:0] ig_r0,
    input  logic [DATA_WIDTH-1:0] ig_r1,
    input  logic [DATA_WIDTH-1:0] ig_r2,
    output logic                  eg_vld,
    input  logic                  eg_rdy,
    output logic [DATA_WIDTH-1:0] eg_r0,
    output logic [DATA_WIDTH-1:0] eg_r1,
    output logic [DATA_WIDTH-1:0] eg_r2
`ifdef MSTREAM_TRANSPOSER_STATS_EN
    ,
    output logic [15:0]           matrix_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_st_e;

    bank_st_e st_q [2];
    bank_st_e st_d [2];
    logic     wr_bank_q, wr_bank_d;
    logic     rd_bank_q, rd_bank_d;
    logic [1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0] rd_cnt_q, rd_cnt_d;
    logic     ig_fire, eg_fire;

    // Indexed [bank][column][row]; data needs no reset.
    logic [DATA_WIDTH-1:0] mem_q [2][3][3];

    always_comb begin
        ig_rdy    = (st_q[wr_bank_q] != FULL);
        eg_vld    = (st_q[rd_bank_q] == FULL);
        ig_fire   = ig_vld && ig_rdy;
        eg_fire   = eg_vld && eg_rdy;
        st_d[0]   = st_q[0];
        st_d[1]   = st_q[1];
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        if (ig_fire) begin
            if (wr_cnt_q == 2'd0) st_d[wr_bank_q] = FILLING;
            if (wr_cnt_q == 2'd2) begin
                st_d[wr_bank_q] = FULL;
                wr_cnt_d        = 2'd0;
                wr_bank_d       = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 2'd1;
            end
        end
        // A FULL bank is never written, so these updates never collide.
        if (eg_fire) begin
            if (rd_cnt_q == 2'd2) begin
                st_d[rd_bank_q] = EMPTY;
                rd_cnt_d        = 2'd0;
                rd_bank_d       = ~rd_bank_q;
            end else begin
                rd_cnt_d = rd_cnt_q + 2'd1;
            end
        end
    end

    always_comb begin
        eg_r0 = '0;
        eg_r1 = '0;
        eg_r2 = '0;
        if (eg_vld) begin
            eg_r0 = mem_q[rd_bank_q][0][rd_cnt_q];
            eg_r1 = mem_q[rd_bank_q][1][rd_cnt_q];
            eg_r2 = mem_q[rd_bank_q][2][rd_cnt_q];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (ig_fire) begin
            mem_q[wr_bank_q][wr_cnt_q][0] <= ig_r0;
            mem_q[wr_bank_q][wr_cnt_q][1] <= ig_r1;
            mem_q[wr_bank_q][wr_cnt_q][2] <= ig_r2;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q[0]   <= EMPTY;
            st_q[1]   <= EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= 2'd0;
            rd_cnt_q  <= 2'd0;
        end else begin
            st_q[0]   <= st_d[0];
            st_q[1]   <= st_d[1];
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

`ifdef MSTREAM_TRANSPOSER_STATS_EN
    logic [15:0] matrix_cnt_q, matrix_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        matrix_cnt_d = matrix_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (eg_fire && rd_cnt_q == 2'd2) matrix_cnt_d = matrix_cnt_q + 16'd1;
        // Stall count saturates instead of wrapping.
        if (eg_vld && !eg_rdy && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            matrix_cnt_q <= 16'd0;
            stall_cnt_q  <= 16'd0;
        end else begin
            matrix_cnt_q <= matrix_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign matrix_cnt = matrix_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule
